// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the UART program loader.
// Loader state encoding, error codes and a byte-shift helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_LEN   = 2'd1;
  localparam logic [1:0] ERR_CKSUM = 2'd2;

  // Little-endian assembly: newest byte enters at the top.
  function automatic logic [31:0] shift_le(
    input logic [31:0] w,
    input logic [7:0]  b
  );
    return {b, w[31:8]};
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// uart_loader_if: rx-buffer pop handshake plus instruction-memory write port.
// master = loader side, slave = rx buffer / memory side.
interface uart_loader_if #(
  parameter int ADDR_W = 14
);
  logic              rx_ready;
  logic [7:0]        rx_data;
  logic              rx_next;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  rx_ready,
    input  rx_data,
    output rx_next,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output rx_ready,
    output rx_data,
    input  rx_next,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/uart_byte_pop.sv
// uart_byte_pop: pops one byte from the rx buffer when enabled.
// The cycle after a pop is dead so the buffer head can update.
module uart_byte_pop (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       rx_next,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  logic       pop_q, pop_d;
  logic [7:0] byte_q, byte_d;

  always_comb begin
    pop_d  = en && rx_ready && !pop_q;
    byte_d = pop_d ? rx_data : byte_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_q  <= 1'b0;
      byte_q <= 8'd0;
    end else begin
      pop_q  <= pop_d;
      byte_q <= byte_d;
    end
  end

  assign rx_next    = pop_q;
  assign byte_valid = pop_q;
  assign byte_data  = byte_q;

endmodule

// File: rtl/uart_loader.sv
// uart_loader: streams a length-prefixed program from the rx buffer into imem.
// Optional trailing checksum byte when UART_LOADER_CKSUM_EN is defined.
module uart_loader
  import uart_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  uart_loader_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam logic [32:0] LEN_MAX = 33'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
`ifdef UART_LOADER_CKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic       pop_en;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       rx_next;
  logic       byte_last;

  assign pop_en    = state_q inside {ST_HDR, ST_DATA, ST_CHK};
  assign byte_last = (byte_idx_q == 2'd3);

  uart_byte_pop u_pop (
    .clk        (clk),
    .rst        (rst),
    .en         (pop_en),
    .rx_ready   (bus.rx_ready),
    .rx_data    (bus.rx_data),
    .rx_next    (rx_next),
    .byte_valid (byte_valid),
    .byte_data  (byte_data)
  );

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    word_cnt_d  = word_cnt_q;
    len_d       = len_q;
    mem_wdata_d = mem_wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
`ifdef UART_LOADER_CKSUM_EN
    sum_d       = sum_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_HDR;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          byte_idx_d = 2'd0;
          word_cnt_d = '0;
`ifdef UART_LOADER_CKSUM_EN
          sum_d      = 8'd0;
`endif
        end
      end
      ST_HDR: begin
        if (byte_valid) begin
          len_d      = shift_le(len_q, byte_data);
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef UART_LOADER_CKSUM_EN
          sum_d      = sum_q + byte_data;
`endif
          if (byte_last) begin
            if ({1'b0, len_d} > LEN_MAX) begin
              state_d    = ST_ERR;
              busy_d     = 1'b0;
              err_d      = 1'b1;
              err_code_d = ERR_LEN;
            end else if (len_d == 32'd0) begin
`ifdef UART_LOADER_CKSUM_EN
              state_d = ST_CHK;
`else
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
`endif
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (byte_valid) begin
          mem_wdata_d = shift_le(mem_wdata_q, byte_data);
          byte_idx_d  = byte_idx_q + 2'd1;
`ifdef UART_LOADER_CKSUM_EN
          sum_d       = sum_q + byte_data;
`endif
          if (byte_last) begin
            state_d    = ST_WRITE;
            mem_we_d   = 1'b1;
            mem_addr_d = BASE + word_cnt_q[ADDR_W-1:0];
          end
        end
      end
      ST_WRITE: begin
        word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
        if (32'(word_cnt_d) == len_q) begin
`ifdef UART_LOADER_CKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_LOADER_CKSUM_EN
      ST_CHK: begin
        if (byte_valid) begin
          busy_d = 1'b0;
          if (byte_data == sum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_CKSUM;
          end
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      byte_idx_q  <= 2'd0;
      word_cnt_q  <= '0;
      len_q       <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_addr_q  <= BASE;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
`ifdef UART_LOADER_CKSUM_EN
      sum_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      word_cnt_q  <= word_cnt_d;
      len_q       <= len_d;
      mem_wdata_q <= mem_wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
`ifdef UART_LOADER_CKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign bus.rx_next   = rx_next;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: random program loads against a byte-stream reference model.
// Honours UART_LOADER_CKSUM_EN for the trailing checksum byte.
module tb_uart_loader;

  localparam int AW   = 4;
  localparam int BASE = 5;
`ifdef UART_LOADER_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy, done, err;
  logic [1:0] err_code;

  uart_loader_if #(.ADDR_W(AW)) bus ();

  uart_loader #(
    .ADDR_W    (AW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus.master),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rx buffer model and bus monitor (owned by the negedge process)
  logic [7:0]    stream [0:4095];
  int            wr_ptr, rd_ptr, rd_floor;
  int            cyc, pops, last_next_cyc, gap_until;
  int            wr_cnt, viol_ready, viol_b2b, viol_lat;
  bit            prev_next, rnd_mode, gate;
  logic [AW-1:0] wr_addr [0:511];
  logic [31:0]   wr_data [0:511];

  always @(negedge clk) begin
    cyc++;
    if (bus.mem_we) begin
      if (cyc != last_next_cyc + 1) viol_lat++;
      wr_addr[wr_cnt & 511] = bus.mem_addr;
      wr_data[wr_cnt & 511] = bus.mem_wdata;
      wr_cnt++;
    end
    if (bus.rx_next) begin
      if (bus.rx_ready !== 1'b1) viol_ready++;
      if (prev_next) viol_b2b++;
      last_next_cyc = cyc;
      rd_ptr++;
      pops++;
    end
    prev_next = bus.rx_next;
    if (rd_ptr < rd_floor) rd_ptr = rd_floor;
    if (cyc < gap_until) gate = 1'b0;
    else gate = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.rx_ready = gate && (rd_ptr < wr_ptr);
    bus.rx_data  = stream[rd_ptr & 4095];
  end

  int          n_checks, n_err;
  logic [7:0]  run_sum;
  logic [31:0] wbuf [0:15];
  int          pb, wb, t;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    stream[wr_ptr & 4095] = b;
    wr_ptr++;
    run_sum = run_sum + b;
  endtask

  task automatic run_load(input int len, input int mode,
                          input logic [7:0] ck_xor);
    int   acc, exp_pops, exp_n, p0, w0, nw, k;
    logic exp_done;
    logic [1:0] exp_code;
    rd_floor = wr_ptr;
    run_sum  = 8'd0;
    acc      = (len <= (1 << AW)) ? 1 : 0;
    for (int b = 0; b < 4; b++) push(8'(len >> (8 * b)));
    if (acc != 0) begin
      for (int i = 0; i < len; i++)
        for (int b = 0; b < 4; b++) push(8'(wbuf[i] >> (8 * b)));
      if (CK != 0) push(run_sum ^ ck_xor);
    end else begin
      for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
    end
    for (int i = 0; i < 3; i++) push(8'h5A);
    exp_pops = 4 + ((acc != 0) ? 4 * len + CK : 0);
    exp_n    = (acc != 0) ? len : 0;
    exp_done = (acc != 0) && !((CK != 0) && (ck_xor != 8'd0));
    exp_code = (acc == 0) ? 2'd1 : (exp_done ? 2'd0 : 2'd2);
    rnd_mode = (mode != 0);
    tick();
    p0 = pops;
    w0 = wr_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (mode == 2) gap_until = cyc + 1000;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (!(done || err) && t < 6000) begin
      tick();
      t++;
    end
    check("finished", done | err, 1);
    repeat (12) tick();
    check("busy_end", busy, 0);
    check("done", done, exp_done);
    check("err", err, !exp_done);
    check("err_code", err_code, exp_code);
    check("pops", pops - p0, exp_pops);
    nw = wr_cnt - w0;
    check("nwrites", nw, exp_n);
    k = (nw < exp_n) ? nw : exp_n;
    for (int i = 0; i < k; i++) begin
      check("wr_addr", wr_addr[(w0 + i) & 511], (BASE + i) % (1 << AW));
      check("wr_data", wr_data[(w0 + i) & 511], wbuf[i]);
    end
    check("viol_ready", viol_ready, 0);
    check("viol_b2b", viol_b2b, 0);
    check("viol_latency", viol_lat, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_next", bus.rx_next, 0);
    check("rst_addr", bus.mem_addr, BASE);
    check("rst_wdata", bus.mem_wdata, 0);
    rst = 1'b0;
    tick();

    wbuf[0] = 32'h0000_0013;
    wbuf[1] = 32'h0010_0093;
    run_load(2, 0, 8'd0);
    run_load(0, 0, 8'd0);
    run_load(17, 0, 8'd0);
`ifdef UART_LOADER_CKSUM_EN
    wbuf[0] = 32'h0403_0201;
    run_load(1, 0, 8'd0);
    run_load(1, 0, 8'h07);
`endif
    wbuf[0] = 32'h0000_0013;
    wbuf[1] = 32'h0010_0093;
    run_load(2, 2, 8'd0);

    // reset in the middle of the second payload word
    rd_floor = wr_ptr;
    run_sum  = 8'd0;
    wbuf[0]  = $urandom;
    wbuf[1]  = $urandom;
    for (int b = 0; b < 4; b++) push(8'(2 >> (8 * b)));
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 4; b++) push(8'(wbuf[i] >> (8 * b)));
    rnd_mode = 1'b0;
    tick();
    pb = pops;
    wb = wr_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while ((pops - pb) < 10 && t < 500) begin
      tick();
      t++;
    end
    check("mid_pops", pops - pb, 10);
    check("mid_nwrites", wr_cnt - wb, 1);
    check("mid_wdata", wr_data[wb & 511], wbuf[0]);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_we", bus.mem_we, 0);
    check("mid_rst_addr", bus.mem_addr, BASE);
    rst   = 1'b0;
    start = 1'b0;
    pb = pops;
    wb = wr_cnt;
    repeat (20) tick();
    check("post_rst_pops", pops - pb, 0);
    check("post_rst_writes", wr_cnt - wb, 0);
    check("post_rst_busy", busy, 0);
    for (int i = 0; i < 2; i++) wbuf[i] = $urandom;
    run_load(2, 1, 8'd0);

    for (int n = 0; n < 6; n++) begin
      int len;
      len = (n == 0) ? 16 : int'($urandom_range(1, 16));
      for (int i = 0; i < len; i++) wbuf[i] = $urandom;
      run_load(len, (n % 2) + 1, (n == 3) ? 8'h01 : 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
